// File: rtl/fmc_la_pkg.sv
// Shared types and default sizing for the FMC LA receive checker.
package fmc_la_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int FMC_LA_WIDTH       = 30;
    localparam int FMC_LA_LOCK_CNT    = 16;
    localparam int FMC_LA_UNLOCK_ERRS = 4;
    localparam int FMC_LA_ERR_CNT_W   = 16;

endpackage

// File: rtl/delay.sv
// Fixed-length register pipeline (LENGTH stages of WIDTH bits), used as a
// synchronizer in front of the checker input register.
module delay #(
    parameter int WIDTH  = 1,
    parameter int LENGTH = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (LENGTH == 1) begin : g_single
            logic [WIDTH-1:0] pipe_q;
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) pipe_q <= '0;
                else       pipe_q <= d;
            end
            assign q = pipe_q;
        end else begin : g_multi
            logic [LENGTH*WIDTH-1:0] pipe_q;
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) pipe_q <= '0;
                else       pipe_q <= {pipe_q[(LENGTH-1)*WIDTH-1:0], d};
            end
            assign q = pipe_q[LENGTH*WIDTH-1 -: WIDTH];
        end
    endgenerate

endmodule

// File: rtl/fmc_la_rx_checker_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && !(&cnt_q)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/fmc_la_rx_checker.sv
// Locks onto an incrementing counter on the FMC LA bus and counts word errors.
// Define FMC_LA_RX_SYNC_EN to add a 2-stage input synchronizer (+2 cycles latency).
module fmc_la_rx_checker
    import fmc_la_pkg::*;
#(
    parameter int WIDTH       = FMC_LA_WIDTH,
    parameter int LOCK_CNT    = FMC_LA_LOCK_CNT,
    parameter int UNLOCK_ERRS = FMC_LA_UNLOCK_ERRS,
    parameter int ERR_CNT_W   = FMC_LA_ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 ena,
    input  logic [WIDTH-1:0]     in,
    input  logic                 clr_err,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [1:0]           state
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(UNLOCK_ERRS + 1);

    logic             ena_s;
    logic [WIDTH-1:0] in_s;

`ifdef FMC_LA_RX_SYNC_EN
    logic [WIDTH:0] sync_out;

    delay #(
        .WIDTH  (WIDTH + 1),
        .LENGTH (2)
    ) u_sync (
        .clk  (clk),
        .nrst (nrst),
        .d    ({ena, in}),
        .q    (sync_out)
    );

    assign {ena_s, in_s} = sync_out;
`else
    assign ena_s = ena;
    assign in_s  = in;
`endif

    // Stage Q: word and its valid qualifier travel together.
    logic             ena_q;
    logic [WIDTH-1:0] word_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ena_q  <= 1'b0;
            word_q <= '0;
        end else begin
            ena_q  <= ena_s;
            word_q <= in_s;
        end
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   expected_q, expected_d;
    logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
    logic [MISS_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic               locked_q;
    logic               err_pulse_q;
    logic               err_d;
    logic               word_match;
    logic [MATCH_W-1:0] match_inc;
    logic [MISS_W-1:0]  miss_inc;

    assign word_match = (word_q == expected_q);
    assign match_inc  = match_cnt_q + 1'b1;
    assign miss_inc   = miss_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_d       = 1'b0;
        if (ena_q) begin
            case (state_q)
                HUNT: begin
                    expected_d  = word_q + 1'b1;
                    match_cnt_d = '0;
                    state_d     = VERIFY;
                end
                VERIFY: begin
                    if (word_match) begin
                        match_cnt_d = match_inc;
                        expected_d  = expected_q + 1'b1;
                        if (match_inc == MATCH_W'(LOCK_CNT)) begin
                            state_d    = LOCKED;
                            miss_cnt_d = '0;
                        end
                    end else begin
                        // The offending word is discarded; the next valid word reseeds.
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    expected_d = expected_q + 1'b1;
                    if (word_match) begin
                        miss_cnt_d = '0;
                    end else begin
                        miss_cnt_d = miss_inc;
                        err_d      = 1'b1;
                        if (miss_inc == MISS_W'(UNLOCK_ERRS)) begin
                            state_d = HUNT;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= HUNT;
            expected_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            locked_q    <= (state_d == LOCKED);
            err_pulse_q <= err_d;
        end
    end

    sat_counter #(
        .W (ERR_CNT_W)
    ) u_err_cnt (
        .clk  (clk),
        .nrst (nrst),
        .inc  (err_d),
        .clr  (clr_err),
        .cnt  (err_cnt)
    );

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign state     = state_q;

endmodule

// File: tb/tb_fmc_la_rx_checker.sv
// Randomized bench for fmc_la_rx_checker against a per-word behavioural model.
module tb_fmc_la_rx_checker;

    logic        clk = 1'b0;
    logic        nrst;
    logic        ena;
    logic [29:0] in_w;
    logic        clr_err;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_cnt;
    logic [1:0]  state;

    fmc_la_rx_checker dut (
        .clk       (clk),
        .nrst      (nrst),
        .ena       (ena),
        .in        (in_w),
        .clr_err   (clr_err),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .state     (state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int txn   = 0;

    // Reference model: link status as a function of the valid-word history.
    int          m_state;   // 0 hunting, 1 verifying, 2 locked
    int          m_match;
    int          m_miss;
    int          m_errs;
    bit          m_pulse;
    logic [29:0] m_exp;

    // Two-deep history of driven inputs, to account for the pipeline latency.
    bit          h_e [2];
    logic [29:0] h_w [2];
    bit          h_c [2];

    logic [29:0] src;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (txn %0d)", tag, got, exp, txn);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_match = 0;
        m_miss  = 0;
        m_errs  = 0;
        m_pulse = 1'b0;
        m_exp   = '0;
        for (int i = 0; i < 2; i++) begin
            h_e[i] = 1'b0;
            h_w[i] = '0;
            h_c[i] = 1'b0;
        end
    endtask

    task automatic model_step(input bit v, input logic [29:0] w, input bit c);
        bit err;
        err = 1'b0;
        if (v) begin
            if (m_state == 0) begin
                m_exp   = w + 30'd1;
                m_match = 0;
                m_state = 1;
            end else if (m_state == 1) begin
                if (w == m_exp) begin
                    m_match++;
                    m_exp = m_exp + 30'd1;
                    if (m_match == 16) begin
                        m_state = 2;
                        m_miss  = 0;
                    end
                end else begin
                    m_state = 0;
                end
            end else begin
                if (w == m_exp) begin
                    m_miss = 0;
                end else begin
                    err = 1'b1;
                    m_miss++;
                    if (m_miss == 4) m_state = 0;
                end
                m_exp = m_exp + 30'd1;
            end
        end
        m_pulse = err;
        if (c)                          m_errs = 0;
        else if (err && m_errs < 65535) m_errs++;
    endtask

    task automatic check_outputs(input string pfx);
        check_val({pfx, "locked"},    32'(locked),    32'(m_state == 2));
        check_val({pfx, "err_pulse"}, 32'(err_pulse), 32'(m_pulse));
        check_val({pfx, "err_cnt"},   32'(err_cnt),   32'(m_errs));
        check_val({pfx, "state"},     32'(state),     32'(m_state));
    endtask

    task automatic cycle(input bit e, input logic [29:0] w, input bit c);
        @(posedge clk);
        #1;
        model_step(h_e[1], h_w[1], h_c[0]);
        check_outputs("");
        $display("txn %0d ena=%0b in=%h clr=%0b | state=%0d locked=%0b pulse=%0b err_cnt=%0d",
                 txn, e, w, c, state, locked, err_pulse, err_cnt);
        txn++;
        ena     = e;
        in_w    = w;
        clr_err = c;
        h_e[1] = h_e[0]; h_w[1] = h_w[0]; h_c[1] = h_c[0];
        h_e[0] = e;      h_w[0] = w;      h_c[0] = c;
    endtask

    // gap_mode: 0 = back-to-back, 1 = alternate idle cycles, 2 = random idles
    task automatic words(input int n, input int gap_mode);
        for (int i = 0; i < n; i++) begin
            if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 3) == 0))
                cycle(1'b0, 30'($urandom), 1'b0);
            cycle(1'b1, src, 1'b0);
            src = src + 30'd1;
        end
    endtask

    // Asynchronous reset between clock edges; outputs must clear without a clock.
    task automatic do_reset();
        ena     = 1'b0;
        clr_err = 1'b0;
        #2;
        nrst = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst_");
        $display("txn %0d async reset asserted | state=%0d locked=%0b err_cnt=%0d",
                 txn, state, locked, err_cnt);
        #1;
        nrst = 1'b1;
    endtask

    initial begin
        nrst    = 1'b0;
        ena     = 1'b0;
        in_w    = '0;
        clr_err = 1'b0;
        src     = '0;
        model_reset();
        #12;
        check_outputs("reset_");
        nrst = 1'b1;

        // Clean count from zero: lock after the 17th word, then one substituted word.
        words(100, 0);
        cycle(1'b1, 30'h0, 1'b0);
        src = src + 30'd1;
        words(30, 0);

        // Four consecutive bad words drop lock; resumed count relocks.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, src ^ 30'h155, 1'b0);
            src = src + 30'd1;
        end
        words(20, 0);

        // Jump near the top of the range: unlock, relock, then wrap while locked.
        src = 30'h3FFF_FFD0;
        words(60, 0);

        // Alternating ena around a clean count.
        words(40, 1);

        // Clear coincident with a bad word.
        cycle(1'b1, src ^ 30'h1, 1'b0);
        src = src + 30'd1;
        cycle(1'b1, src, 1'b1);
        src = src + 30'd1;
        words(5, 0);

        // Randomized traffic: idle gaps, corrupted words, clears, occasional jumps.
        for (int i = 0; i < 400; i++) begin
            bit          e;
            bit          c;
            logic [29:0] w;
            if ($urandom_range(0, 199) == 0) src = 30'($urandom);
            e = ($urandom_range(0, 99) < 80);
            c = ($urandom_range(0, 99) < 2);
            if (e) begin
                w = src;
                if ($urandom_range(0, 99) < 4) w = src ^ (30'($urandom) | 30'h1);
                src = src + 30'd1;
            end else begin
                w = 30'($urandom);
            end
            cycle(e, w, c);
        end

        // Reset mid-verify and mid-locked.
        do_reset();
        src = 30'($urandom);
        words(6, 0);
        do_reset();
        words(25, 2);
        do_reset();
        words(20, 0);

        // Drain the pipeline so the final words are checked.
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
